sys_rst_gen: RTL and testbench
==============================

SYS_RST_GEN -- requirements
Module: sys_rst_gen

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: minimum sys_reset_o high time, in sys_clock_i cycles; legal range 2..255.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for sys_reset_i release; legal range 2..4.
REQ-003 Parameter WDOG_BITS, default 20: watchdog counter width.
REQ-004 sys_clock_i  input  1  system clock; single clock domain.
REQ-005 sys_reset_i  input  1  external reset; asynchronous, active-high.
REQ-006 sw_reset_req_i  input  1  synchronous soft-reset request, sampled each rising edge.
REQ-007 wdog_en_i  input  1  watchdog enable, level.
REQ-008 wdog_kick_i  input  1  watchdog restart, sampled each rising edge.
REQ-009 sys_reset_o  output  1  registered reset to the downstream reset controller, active-high.
REQ-010 reset_cause_o  output  2  cause of the last reset: 01 external, 10 software, 11 watchdog; 00 is never driven.
REQ-011 wdog_count_o  output  WDOG_BITS  current watchdog count, for debug.

Function
REQ-012 States: HOLD (sys_reset_o=1) and RUN (sys_reset_o=0), plus a hold counter (8 bits) and a watchdog counter (WDOG_BITS).
REQ-013 sys_reset_i high: immediately, without a clock, force HOLD, sys_reset_o=1, hold counter=0, watchdog=0, and reset_cause_o=01.
REQ-014 sys_reset_i release: pass through the SYNC_STAGES synchronizer; the hold counter is frozen at 0 until the synchronized reset is low.
REQ-015 In HOLD with the synchronized reset low: the hold counter increments once per edge.
REQ-016 When the hold counter equals HOLD_CYCLES-1, the next edge enters RUN and sys_reset_o goes 0.
REQ-017 External release timing: sys_reset_o falls exactly SYNC_STAGES+HOLD_CYCLES edges after the first edge that samples sys_reset_i low.
REQ-018 In RUN, sw_reset_req_i=1 at edge N: enter HOLD at edge N, with hold counter=0, cause=10 and watchdog=0; sys_reset_o stays high for exactly HOLD_CYCLES cycles.
REQ-019 Watchdog counting: in RUN with wdog_en_i=1, the counter increments per edge; wdog_kick_i=1 clears it to 0 instead.
REQ-020 With wdog_en_i=0, the watchdog holds its value.
REQ-021 Watchdog expiry: counter all-ones, wdog_en_i=1 and wdog_kick_i=0 at an edge causes that edge to enter HOLD with cause=11; the counter never wraps.
REQ-022 Kick during the all-ones cycle clears the counter; no reset occurs.
REQ-023 Same-edge sw_reset_req_i and watchdog expiry: enter HOLD with cause=11 (watchdog wins).
REQ-024 In HOLD, sw_reset_req_i, wdog_kick_i and wdog_en_i are ignored; the hold counter is not restarted, and the watchdog is held at 0.
REQ-025 reset_cause_o changes only on entry to HOLD; it is stable through the following RUN period.
REQ-026 sys_reset_i asserted mid-HOLD or mid-RUN: REQ-013 applies immediately, overriding any soft or watchdog reset in progress.

Reset
REQ-027 Reset values: sys_reset_o=1, reset_cause_o=01, wdog_count_o=0, state=HOLD, hold counter=0, all synchronizer flops=1.
REQ-028 sys_reset_i is the only asynchronous clear; no flop outside rst_sync uses it for deassertion timing.

Structure
REQ-029 s1_defs.h holds the shared constants:
- cause encodings: RST_CAUSE_EXT, RST_CAUSE_SW, RST_CAUSE_WDOG;
- defaults: RST_HOLD_CYCLES, RST_SYNC_STAGES, WDOG_BITS;
- state encodings.
REQ-030 Sub-module rst_sync:
- a SYNC_STAGES-deep chain with asynchronous assert and synchronous deassert;
- a chain of 1-flops, input tied 0, reset by sys_reset_i;
- its output feeds the hold logic.
REQ-031 Target size: 120-250 lines of RTL total.

Verification
REQ-032 Power-on test (bench parameters HOLD_CYCLES=16, SYNC_STAGES=2, WDOG_BITS=8):
- stimulus: sys_reset_i high for 5 cycles, then low;
- required: sys_reset_o falls exactly 18 edges after release, with reset_cause_o=01.
REQ-033 Soft reset:
- stimulus: in RUN, one-cycle sw_reset_req_i pulse;
- required: sys_reset_o high for exactly 16 cycles, then reset_cause_o=10 and wdog_count_o=0.
REQ-034 Watchdog expiry:
- stimulus: wdog_en_i=1, no kicks, starting from 0;
- required: reset enters at the 256th enabled edge (count reaches 255, then expiry), sys_reset_o high 16 cycles, reset_cause_o=11.
REQ-035 Kick at the terminal count:
- stimulus: wdog_kick_i=1 exactly when wdog_count_o=255;
- required: count goes to 0 with no reset; also, same-edge sw_reset_req_i and expiry give reset_cause_o=11.
REQ-036 External reset during a soft reset:
- stimulus: sys_reset_i asserted asynchronously, mid-cycle, during soft-reset HOLD count 7;
- required: cause immediately becomes 01; after release, the full 18-edge sequence restarts.
REQ-037 Ignored inputs in HOLD:
- stimulus: sw_reset_req_i and wdog_kick_i toggled every cycle throughout HOLD;
- required: HOLD length is unchanged at 16 cycles.

Source files
------------

// File: rtl/sys_rst_gen_pkg.sv
// Shared constants for the system reset generator: cause codes, parameter
// defaults and FSM state encodings.
package sys_rst_gen_pkg;

    localparam int unsigned RST_HOLD_CYCLES = 16;
    localparam int unsigned RST_SYNC_STAGES = 2;
    localparam int unsigned RST_WDOG_BITS   = 20;
    localparam int unsigned HOLD_CNT_BITS   = 8;
    localparam int unsigned CAUSE_BITS      = 2;

    typedef logic [CAUSE_BITS-1:0] cause_t;

    localparam cause_t RST_CAUSE_EXT  = 2'b01;
    localparam cause_t RST_CAUSE_SW   = 2'b10;
    localparam cause_t RST_CAUSE_WDOG = 2'b11;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sys_rst_gen_rst_sync.sv
// Reset release synchronizer: asserts asynchronously with the external reset,
// deasserts after STAGES rising edges of the local clock.
module sys_rst_gen_rst_sync
    import sys_rst_gen_pkg::*;
#(
    parameter int unsigned STAGES = RST_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_async,
    output logic rst_synced
);

    logic [STAGES-1:0] chain;

    // Ones are preset by the reset; zeros shift in once it is released.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b0};
        end
    end

    assign rst_synced = chain[STAGES-1];

endmodule

// File: rtl/sys_rst_gen.sv
// System reset generator: stretches external, software and watchdog resets
// into a fixed-length registered reset and records the cause of the last one.
module sys_rst_gen
    import sys_rst_gen_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = RST_HOLD_CYCLES,
    parameter int unsigned SYNC_STAGES = RST_SYNC_STAGES,
    parameter int unsigned WDOG_BITS   = RST_WDOG_BITS
) (
    input  logic                 sys_clock_i,
    input  logic                 sys_reset_i,
    input  logic                 sw_reset_req_i,
    input  logic                 wdog_en_i,
    input  logic                 wdog_kick_i,
    output logic                 sys_reset_o,
    output logic [1:0]           reset_cause_o,
    output logic [WDOG_BITS-1:0] wdog_count_o
);

    localparam logic [HOLD_CNT_BITS-1:0] HOLD_LAST = HOLD_CNT_BITS'(HOLD_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [HOLD_CNT_BITS-1:0] hold_q, hold_d;
    logic [WDOG_BITS-1:0]     wdog_q, wdog_d;
    cause_t                   cause_q, cause_d;
    logic                     rst_q;
    logic                     rst_synced;
    logic                     wdog_expire;

    sys_rst_gen_rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk        (sys_clock_i),
        .rst_async  (sys_reset_i),
        .rst_synced (rst_synced)
    );

    assign wdog_expire = wdog_en_i && !wdog_kick_i && (&wdog_q);

    always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
        if (sys_reset_i) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            wdog_q  <= '0;
            cause_q <= RST_CAUSE_EXT;
            rst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            wdog_q  <= wdog_d;
            cause_q <= cause_d;
            rst_q   <= (state_d == ST_HOLD);
        end
    end

    // Watchdog expiry outranks a same-edge software request.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        wdog_d  = wdog_q;
        cause_d = cause_q;
        unique case (state_q)
            ST_HOLD: begin
                wdog_d = '0;
                if (!rst_synced) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_RUN;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HOLD_CNT_BITS'(1);
                    end
                end
            end
            ST_RUN: begin
                if (wdog_expire) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                    wdog_d  = '0;
                    cause_d = RST_CAUSE_WDOG;
                end else if (sw_reset_req_i) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                    wdog_d  = '0;
                    cause_d = RST_CAUSE_SW;
                end else if (wdog_en_i) begin
                    wdog_d = wdog_kick_i ? '0 : wdog_q + WDOG_BITS'(1);
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    assign sys_reset_o   = rst_q;
    assign reset_cause_o = cause_q;
    assign wdog_count_o  = wdog_q;

endmodule

// File: tb/tb_sys_rst_gen.sv
// Scenario bench for sys_rst_gen: expected reset pulses are queued when the
// triggering stimulus is driven and compared when sys_reset_o falls.
module tb_sys_rst_gen;

    localparam int unsigned HOLD  = 16;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned WBITS = 8;
    localparam int          BUDGET = 100;

    typedef struct {
        int         len;
        logic [1:0] cause;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sw = 1'b0;
    logic             en = 1'b0;
    logic             kick = 1'b0;
    logic             sys_reset_o;
    logic [1:0]       reset_cause_o;
    logic [WBITS-1:0] wdog_count_o;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    sys_rst_gen #(
        .HOLD_CYCLES (HOLD),
        .SYNC_STAGES (SYNC),
        .WDOG_BITS   (WBITS)
    ) dut (
        .sys_clock_i    (clk),
        .sys_reset_i    (rst),
        .sw_reset_req_i (sw),
        .wdog_en_i      (en),
        .wdog_kick_i    (kick),
        .sys_reset_o    (sys_reset_o),
        .reset_cause_o  (reset_cause_o),
        .wdog_count_o   (wdog_count_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until sys_reset_o is seen low; -1 if the budget runs out.
    task automatic measure_hold(input bit toggle, output int len);
        len = -1;
        for (int k = 1; k <= BUDGET; k++) begin
            step();
            if (sys_reset_o === 1'b0) begin
                len = k;
                break;
            end
            if (toggle) begin
                sw   = ~sw;
                kick = ~kick;
            end
        end
        sw   = 1'b0;
        kick = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        int   len;
        #3 rst = 1'b1;
        #1;
        checks++;
        if (sys_reset_o !== 1'b1 || reset_cause_o !== 2'b01 || wdog_count_o !== 8'd0) begin
            errors++;
            $display("FAIL reset_values: rst=%b cause=%b wdog=%0d expected rst=1 cause=01 wdog=0",
                     sys_reset_o, reset_cause_o, wdog_count_o);
        end
        repeat (5) step();
        checks++;
        if (sys_reset_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_held: rst=%b expected 1", sys_reset_o);
        end
        rst = 1'b0;
        exp_q.push_back('{len: int'(SYNC + HOLD), cause: 2'b01});
        measure_hold(1'b0, len);
        e = exp_q.pop_front();
        checks++;
        if (len !== e.len || reset_cause_o !== e.cause) begin
            errors++;
            $display("FAIL power_on: edges=%0d cause=%b expected edges=%0d cause=%b",
                     len, reset_cause_o, e.len, e.cause);
        end
    endtask

    task automatic test_soft_reset();
        exp_t e;
        int   len;
        en = 1'b1;
        repeat (10) step();
        checks++;
        if (wdog_count_o !== 8'd10) begin
            errors++;
            $display("FAIL wdog_count10: got %0d expected 10", wdog_count_o);
        end
        en = 1'b0;
        sw = 1'b1;
        exp_q.push_back('{len: int'(HOLD), cause: 2'b10});
        step();
        sw = 1'b0;
        checks++;
        if (sys_reset_o !== 1'b1 || reset_cause_o !== 2'b10) begin
            errors++;
            $display("FAIL soft_entry: rst=%b cause=%b expected rst=1 cause=10",
                     sys_reset_o, reset_cause_o);
        end
        measure_hold(1'b0, len);
        e = exp_q.pop_front();
        checks++;
        if (len !== e.len || reset_cause_o !== e.cause || wdog_count_o !== 8'd0) begin
            errors++;
            $display("FAIL soft_reset: cycles=%0d cause=%b wdog=%0d expected cycles=%0d cause=%b wdog=0",
                     len, reset_cause_o, wdog_count_o, e.len, e.cause);
        end
    endtask

    task automatic test_kick_terminal();
        exp_t e;
        int   len;
        en = 1'b1;
        repeat (255) step();
        checks++;
        if (wdog_count_o !== 8'd255 || sys_reset_o !== 1'b0) begin
            errors++;
            $display("FAIL wdog_full: wdog=%0d rst=%b expected wdog=255 rst=0", wdog_count_o, sys_reset_o);
        end
        kick = 1'b1;
        step();
        kick = 1'b0;
        checks++;
        if (wdog_count_o !== 8'd0 || sys_reset_o !== 1'b0) begin
            errors++;
            $display("FAIL kick_terminal: wdog=%0d rst=%b expected wdog=0 rst=0", wdog_count_o, sys_reset_o);
        end
        step();
        checks++;
        if (wdog_count_o !== 8'd1) begin
            errors++;
            $display("FAIL after_kick: wdog=%0d expected 1", wdog_count_o);
        end
        repeat (254) step();
        sw = 1'b1;
        exp_q.push_back('{len: int'(HOLD), cause: 2'b11});
        step();
        sw = 1'b0;
        checks++;
        if (sys_reset_o !== 1'b1 || reset_cause_o !== 2'b11 || wdog_count_o !== 8'd0) begin
            errors++;
            $display("FAIL same_edge: rst=%b cause=%b wdog=%0d expected rst=1 cause=11 wdog=0",
                     sys_reset_o, reset_cause_o, wdog_count_o);
        end
        measure_hold(1'b0, len);
        en = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (len !== e.len || reset_cause_o !== e.cause) begin
            errors++;
            $display("FAIL same_edge_hold: cycles=%0d cause=%b expected cycles=%0d cause=%b",
                     len, reset_cause_o, e.len, e.cause);
        end
    endtask

    task automatic test_watchdog();
        exp_t e;
        int   len;
        en = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            if (k == 256) exp_q.push_back('{len: int'(HOLD), cause: 2'b11});
            step();
            if (k == 100 || k == 255) begin
                checks++;
                if (wdog_count_o !== WBITS'(k) || sys_reset_o !== 1'b0) begin
                    errors++;
                    $display("FAIL wdog_count: edge=%0d wdog=%0d rst=%b expected wdog=%0d rst=0",
                             k, wdog_count_o, sys_reset_o, k);
                end
            end
        end
        checks++;
        if (sys_reset_o !== 1'b1 || reset_cause_o !== 2'b11 || wdog_count_o !== 8'd0) begin
            errors++;
            $display("FAIL wdog_expiry: rst=%b cause=%b wdog=%0d expected rst=1 cause=11 wdog=0",
                     sys_reset_o, reset_cause_o, wdog_count_o);
        end
        measure_hold(1'b0, len);
        en = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (len !== e.len || reset_cause_o !== e.cause || wdog_count_o !== 8'd0) begin
            errors++;
            $display("FAIL wdog_hold: cycles=%0d cause=%b wdog=%0d expected cycles=%0d cause=%b wdog=0",
                     len, reset_cause_o, wdog_count_o, e.len, e.cause);
        end
    endtask

    task automatic test_ignored_in_hold();
        exp_t e;
        int   len;
        sw = 1'b1;
        exp_q.push_back('{len: int'(HOLD), cause: 2'b10});
        step();
        sw = 1'b0;
        en = 1'b1;
        measure_hold(1'b1, len);
        en = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (len !== e.len || reset_cause_o !== e.cause || wdog_count_o !== 8'd0) begin
            errors++;
            $display("FAIL ignored_in_hold: cycles=%0d cause=%b wdog=%0d expected cycles=%0d cause=%b wdog=0",
                     len, reset_cause_o, wdog_count_o, e.len, e.cause);
        end
    endtask

    task automatic test_ext_during_soft();
        exp_t e;
        int   len;
        sw = 1'b1;
        step();
        sw = 1'b0;
        repeat (7) step();
        checks++;
        if (sys_reset_o !== 1'b1 || reset_cause_o !== 2'b10) begin
            errors++;
            $display("FAIL soft_count7: rst=%b cause=%b expected rst=1 cause=10", sys_reset_o, reset_cause_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (reset_cause_o !== 2'b01 || sys_reset_o !== 1'b1 || wdog_count_o !== 8'd0) begin
            errors++;
            $display("FAIL ext_async: cause=%b rst=%b wdog=%0d expected cause=01 rst=1 wdog=0",
                     reset_cause_o, sys_reset_o, wdog_count_o);
        end
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        exp_q.push_back('{len: int'(SYNC + HOLD), cause: 2'b01});
        measure_hold(1'b0, len);
        e = exp_q.pop_front();
        checks++;
        if (len !== e.len || reset_cause_o !== e.cause) begin
            errors++;
            $display("FAIL ext_restart: edges=%0d cause=%b expected edges=%0d cause=%b",
                     len, reset_cause_o, e.len, e.cause);
        end
    endtask

    initial begin
        test_reset();
        test_soft_reset();
        test_kick_terminal();
        test_watchdog();
        test_ignored_in_hold();
        test_ext_during_soft();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
